// File: rtl/multicycle_adder_ctrl_if.sv
// Operation request/result bundle for the multi-cycle adder controller.
// Handshake: the master raises start with A/B/sub valid; the operation is taken
// on a rising edge only while ready=1 (start is ignored otherwise, not queued).
// The slave pulses done for one cycle when S and the flags are valid; S and the
// flags then hold until the next accepted start.
interface multicycle_adder_ctrl_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             COUT;
   logic             OVF;
   logic             ZERO;

   // Requester side (ALU control FSM / testbench).
   modport master (
      output start, sub, A, B,
      input  ready, busy, done, S, COUT, OVF, ZERO
   );

   // Adder controller side.
   modport slave (
      input  start, sub, A, B,
      output ready, busy, done, S, COUT, OVF, ZERO
   );
endinterface

// File: rtl/multicycle_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built from one SLICE-bit adder slice reused
// over WIDTH/SLICE cycles, with a carry register between slices.
// Subtraction is A + ~B + 1: B is inverted at accept time and the carry
// register starts at 1.
module multicycle_adder_ctrl #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   multicycle_adder_ctrl_if.slave       bus,
   output logic [1:0]                   stateDbg
);

   localparam int NSLICES = WIDTH / SLICE;
   localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            stateNext;

   logic [WIDTH-1:0]  opA;
   logic [WIDTH-1:0]  opB;
   logic              carry;
   logic [IDXW-1:0]   idx;
   logic [WIDTH-1:0]  sReg;
   logic              coutReg;
   logic              ovfReg;
   logic              zeroReg;

   logic [SLICE-1:0]  sliceA;
   logic [SLICE-1:0]  sliceB;
   logic [SLICE:0]    sliceSum;
   logic              cinMsb;
   logic [WIDTH-1:0]  sNext;
   logic              lastSlice;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic: RUN lasts exactly NSLICES cycles, DONE exactly one.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (bus.start) stateNext = RUN;
         RUN:     if (lastSlice) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Slice adder for the current index, plus the full result as it will look
   // once this slice is written (needed for ZERO on the final slice).
   always_comb begin
      sliceA    = opA[idx*SLICE +: SLICE];
      sliceB    = opB[idx*SLICE +: SLICE];
      sliceSum  = {1'b0, sliceA} + {1'b0, sliceB} + {{SLICE{1'b0}}, carry};
      // Carry into the top bit of the slice recovered from its sum bit:
      // s = a ^ b ^ cin  =>  cin = s ^ a ^ b. On the last slice this is the
      // carry into bit WIDTH-1.
      cinMsb    = sliceSum[SLICE-1] ^ sliceA[SLICE-1] ^ sliceB[SLICE-1];
      sNext     = sReg;
      sNext[idx*SLICE +: SLICE] = sliceSum[SLICE-1:0];
      lastSlice = (idx == LAST_IDX);
   end

   // Datapath: operand capture on accept, one slice per RUN cycle, flags on
   // the last slice. Results hold through DONE and IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         opA     <= '0;
         opB     <= '0;
         carry   <= 1'b0;
         idx     <= '0;
         sReg    <= '0;
         coutReg <= 1'b0;
         ovfReg  <= 1'b0;
         zeroReg <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  opA     <= bus.A;
                  opB     <= bus.sub ? ~bus.B : bus.B;
                  carry   <= bus.sub;
                  idx     <= '0;
                  sReg    <= '0;
                  coutReg <= 1'b0;
                  ovfReg  <= 1'b0;
                  zeroReg <= 1'b0;
               end
            end
            RUN: begin
               sReg  <= sNext;
               carry <= sliceSum[SLICE];
               if (lastSlice) begin
                  coutReg <= sliceSum[SLICE];
                  ovfReg  <= cinMsb ^ sliceSum[SLICE];
                  zeroReg <= (sNext == '0);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Handshake status decoded directly from the state.
   assign bus.ready = (state == IDLE);
   assign bus.busy  = (state == RUN);
   assign bus.done  = (state == DONE);
   assign bus.S     = sReg;
   assign bus.COUT  = coutReg;
   assign bus.OVF   = ovfReg;
   assign bus.ZERO  = zeroReg;
   assign stateDbg  = state;

endmodule

// File: tb/tb_multicycle_adder_ctrl.sv
// Bench for multicycle_adder_ctrl: directed cases plus random operations.
// Expected results come from a plain-arithmetic model and go into a queue at
// issue time; a monitor pops and compares whenever done is seen.
module tb_multicycle_adder_ctrl;

   localparam int WIDTH   = 64;
   localparam int NSLICES = 4;
   localparam int EW      = WIDTH + 3;

   logic       clk;
   logic       reset;
   logic [1:0] stateDbg;
   int         cyc;
   int         checks;
   int         failures;
   bit         prevDone;

   logic [EW-1:0] expQ[$];
   int            doneCycQ[$];

   multicycle_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

   multicycle_adder_ctrl #(.WIDTH(WIDTH), .SLICE(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .stateDbg (stateDbg)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: plain integer add/subtract with signed overflow from operand
   // and result signs; for subtract the carry means "no borrow", i.e. A >= B.
   function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic s);
      logic [WIDTH:0]   full;
      logic [WIDTH-1:0] r;
      logic             co;
      logic             ov;
      if (s) begin
         r  = a - b;
         co = (a >= b);
         ov = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end else begin
         full = {1'b0, a} + {1'b0, b};
         r  = full[WIDTH-1:0];
         co = full[WIDTH];
         ov = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      return {r, co, ov, (r == '0)};
   endfunction

   // Driver: wait (bounded) for ready, present the op, let one edge accept it,
   // then scramble the inputs so late changes would show up as errors.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
      int waited;
      waited = 0;
      @(negedge clk);
      while (!bus.ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.ready) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout actual=%0d required=1", bus.ready);
         return;
      end
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      bus.sub   = s;
      expQ.push_back(model(a, b, s));
      doneCycQ.push_back(cyc + 1 + NSLICES);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.A     = {$urandom, $urandom};
      bus.B     = {$urandom, $urandom};
      bus.sub   = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_drain();
      int waited;
      waited = 0;
      while (expQ.size() != 0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (expQ.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d required=0", expQ.size());
         expQ.delete();
         doneCycQ.delete();
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_ready"}, 64'(bus.ready), 64'd1);
      chk({tag, "_busy"},  64'(bus.busy),  64'd0);
      chk({tag, "_done"},  64'(bus.done),  64'd0);
      chk({tag, "_S"},     bus.S,          64'd0);
      chk({tag, "_flags"}, 64'({bus.COUT, bus.OVF, bus.ZERO}), 64'd0);
   endtask

   // Monitor: compare on every done, check the one-cycle pulse and ready return.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      int            dc;
      if (reset) begin
         prevDone = 1'b0;
      end else begin
         if (prevDone) begin
            chk("done_width", 64'(bus.done), 64'd0);
            chk("ready_after_done", 64'(bus.ready), 64'd1);
         end
         if (bus.done) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0 S=%h", bus.S);
            end else begin
               e  = expQ.pop_front();
               dc = doneCycQ.pop_front();
               chk("result_S", bus.S, e[EW-1:3]);
               chk("result_COUT", 64'(bus.COUT), 64'(e[2]));
               chk("result_OVF", 64'(bus.OVF), 64'(e[1]));
               chk("result_ZERO", 64'(bus.ZERO), 64'(e[0]));
               chk("done_latency", 64'(cyc), 64'(dc));
            end
         end
         prevDone = bus.done;
      end
   end

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      checks    = 0;
      failures  = 0;
      cyc       = 0;
      prevDone  = 1'b0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_state("reset");

      // Carry across a slice boundary; busy must cover exactly NSLICES cycles.
      issue(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
      for (int i = 0; i < NSLICES; i++) begin
         @(negedge clk);
         chk("busy_run", 64'({bus.busy, bus.ready}), 64'b10);
      end
      @(negedge clk);
      chk("busy_in_done", 64'(bus.busy), 64'd0);
      wait_drain();

      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      issue(64'h8000_0000_0000_0000, 64'd1, 1'b1);
      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      issue(64'd5, 64'd7, 1'b1);
      wait_drain();

      // Start during RUN is ignored and does not disturb the operands.
      issue(64'd3, 64'd4, 1'b0);
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 64'd100;
      bus.B     = 64'd200;
      bus.sub   = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.A     = 64'd555;
      bus.B     = 64'd777;
      wait_drain();
      repeat (3) @(negedge clk);
      issue(64'd100, 64'd200, 1'b0);
      wait_drain();

      // Reset on the second RUN cycle aborts the operation.
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      expQ.delete();
      doneCycQ.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_state("abort");
      repeat (6) @(negedge clk);
      issue(64'd10, 64'd3, 1'b1);
      wait_drain();

      // Random operations with occasional edge-case operands and idle gaps.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: ra = '1;
            1: ra = {1'b1, 63'd0};
            default: ra = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = 64'($urandom_range(0, 3));
            default: rb = {$urandom, $urandom};
         endcase
         issue(ra, rb, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
